fram_spi_ctrl: RTL

FRAM_SPI_CTRL -- requirements
Module: fram_spi_ctrl

---
 rtl/fram_spi_ctrl_pkg.sv | 27 ++
 rtl/fram_spi_ctrl_spi_byte_shift.sv | 80 ++++++++
 rtl/fram_spi_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fram_spi_ctrl_pkg.sv
// Shared FRAM SPI definitions: device opcodes, controller state encoding and a
// small helper used for timer reload values.
package fram_spi_ctrl_pkg;

  typedef logic [3:0] fram_state_t;

  localparam fram_state_t ST_IDLE    = 4'd0;
  localparam fram_state_t ST_WREN    = 4'd1;
  localparam fram_state_t ST_CS_GAP  = 4'd2;
  localparam fram_state_t ST_CMD     = 4'd3;
  localparam fram_state_t ST_ADDR_H  = 4'd4;
  localparam fram_state_t ST_ADDR_L  = 4'd5;
  localparam fram_state_t ST_WR_WAIT = 4'd6;
  localparam fram_state_t ST_WR_BYTE = 4'd7;
  localparam fram_state_t ST_RD_BYTE = 4'd8;
  localparam fram_state_t ST_CS_END  = 4'd9;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  // Down-counters terminate on zero, so an N-cycle wait reloads with N-1.
  function automatic logic [15:0] tmr_load(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/fram_spi_ctrl_spi_byte_shift.sv
// Mode-0 SPI byte shifter with SCK divider: MOSI moves on falling edges, MISO
// is sampled on rising edges, MSB first. done_o flags the edge of the last fall.
module spi_byte_shift #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stall_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic       rx_last_o,
  output logic [7:0] rx_byte_o
);

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

  logic       active_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic       sck_q;
  logic       mosi_q;
  logic       rx_last_q;
  logic       tick;

  assign tick      = active_q && !stall_i && (div_q == 8'd0);
  // Combinational so the owner can issue the next start on this same edge and
  // keep back-to-back bytes at an exact half-period.
  assign done_o    = tick && sck_q && (bit_q == 3'd7);
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign rx_last_o = rx_last_q;
  assign rx_byte_o = rx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= 1'b0;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      rx_last_q <= 1'b0;
    end else begin
      rx_last_q <= 1'b0;
      if (start_i) begin
        active_q <= 1'b1;
        div_q    <= DIV_LD;
        bit_q    <= 3'd0;
        tx_q     <= {tx_byte_i[6:0], 1'b0};
        mosi_q   <= tx_byte_i[7];
        sck_q    <= 1'b0;
      end else if (active_q && !stall_i) begin
        if (div_q != 8'd0) begin
          div_q <= div_q - 8'd1;
        end else begin
          div_q <= DIV_LD;
          sck_q <= ~sck_q;
          if (!sck_q) begin
            rx_q      <= {rx_q[6:0], miso_i};
            rx_last_q <= (bit_q == 3'd7);
          end else if (bit_q == 3'd7) begin
            active_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            mosi_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/fram_spi_ctrl.sv
// FRAM SPI master: sequences WREN / WRITE / READ frames, requests write bytes
// one at a time with a timeout, and streams read bytes out without backpressure.
module fram_spi_ctrl
  import fram_spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int WR_TMO  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fram_rden,
  input  logic        i_fram_wren,
  input  logic [15:0] im_fram_addr,
  input  logic [15:0] im_fram_wr_len,
  input  logic        i_fram_wr_dv,
  input  logic [7:0]  im_fram_wdata,
  output logic        o_fram_wr_req,
  output logic        o_fram_rd_dv,
  output logic [7:0]  om_fram_rdata,
  output logic        o_fram_rdy,
  output logic        o_fram_err,
  output logic        o_spi_cs_n,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam logic [15:0] TAIL_LD = tmr_load(CLK_DIV);
  localparam logic [15:0] GAP_LD  = tmr_load(2 * CLK_DIV);
  localparam logic [15:0] TMO_LD  = tmr_load(WR_TMO);

  fram_state_t state_q, state_d;
  logic        tail_q, tail_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        cs_n_q, cs_n_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_dv_q;
  logic [7:0]  rdata_q;

  logic        shift_start;
  logic [7:0]  shift_tx;
  logic        shift_done;
  logic        shift_rx_last;
  logic [7:0]  shift_rx_byte;
  logic        rd_capture;

  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .start_i   (shift_start),
    .stall_i   (state_q == ST_WR_WAIT),
    .tx_byte_i (shift_tx),
    .miso_i    (i_spi_miso),
    .sck_o     (o_spi_sck),
    .mosi_o    (o_spi_mosi),
    .done_o    (shift_done),
    .rx_last_o (shift_rx_last),
    .rx_byte_o (shift_rx_byte)
  );

  assign rd_capture = shift_rx_last && (state_q == ST_RD_BYTE);

  always_comb begin
    state_d     = state_q;
    tail_d      = tail_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    cs_n_d      = cs_n_q;
    rdy_d       = rdy_q;
    err_d       = 1'b0;
    wr_req_d    = 1'b0;
    shift_start = 1'b0;
    shift_tx    = 8'h00;
    // Tail: hold CS_n low one half-period past the final SCK fall of a frame.
    if (tail_q) begin
      if (timer_q == 16'd0) begin
        tail_d  = 1'b0;
        cs_n_d  = 1'b1;
        timer_d = GAP_LD;
        state_d = (state_q == ST_WREN) ? ST_CS_GAP : ST_CS_END;
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_fram_rden && i_fram_wren) begin
            err_d = 1'b1;
          end else if (i_fram_rden || i_fram_wren) begin
            rdy_d  = 1'b0;
            addr_d = im_fram_addr;
            cnt_d  = im_fram_wr_len;
            wr_d   = i_fram_wren;
            if (im_fram_wr_len == 16'd0) begin
              state_d = ST_CS_END;
              timer_d = 16'd0;
            end else begin
              cs_n_d      = 1'b0;
              shift_start = 1'b1;
              shift_tx    = i_fram_wren ? OP_WREN : OP_READ;
              state_d     = i_fram_wren ? ST_WREN : ST_CMD;
            end
          end
        end
        ST_WREN: begin
          if (shift_done) begin
            tail_d  = 1'b1;
            timer_d = TAIL_LD;
          end
        end
        ST_CS_GAP: begin
          if (timer_q == 16'd0) begin
            state_d     = ST_CMD;
            cs_n_d      = 1'b0;
            shift_start = 1'b1;
            shift_tx    = OP_WRITE;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_CMD: begin
          if (shift_done) begin
            state_d     = ST_ADDR_H;
            shift_start = 1'b1;
            shift_tx    = addr_q[15:8];
          end
        end
        ST_ADDR_H: begin
          if (shift_done) begin
            state_d     = ST_ADDR_L;
            shift_start = 1'b1;
            shift_tx    = addr_q[7:0];
          end
        end
        ST_ADDR_L: begin
          if (shift_done) begin
            if (wr_q) begin
              state_d  = ST_WR_WAIT;
              wr_req_d = 1'b1;
              timer_d  = TMO_LD;
            end else begin
              state_d     = ST_RD_BYTE;
              shift_start = 1'b1;
            end
          end
        end
        ST_WR_WAIT: begin
          if (i_fram_wr_dv) begin
            state_d     = ST_WR_BYTE;
            shift_start = 1'b1;
            shift_tx    = im_fram_wdata;
          end else if (timer_q == 16'd0) begin
            err_d   = 1'b1;
            cs_n_d  = 1'b1;
            state_d = ST_CS_END;
            timer_d = GAP_LD;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_WR_BYTE: begin
          if (shift_done) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              tail_d  = 1'b1;
              timer_d = TAIL_LD;
            end else begin
              state_d  = ST_WR_WAIT;
              wr_req_d = 1'b1;
              timer_d  = TMO_LD;
            end
          end
        end
        ST_RD_BYTE: begin
          if (shift_done) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              tail_d  = 1'b1;
              timer_d = TAIL_LD;
            end else begin
              shift_start = 1'b1;
            end
          end
        end
        ST_CS_END: begin
          if (timer_q == 16'd0) begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          rdy_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tail_q   <= 1'b0;
      timer_q  <= 16'd0;
      cnt_q    <= 16'd0;
      addr_q   <= 16'd0;
      wr_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      wr_req_q <= 1'b0;
      rd_dv_q  <= 1'b0;
      rdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      tail_q   <= tail_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      cs_n_q   <= cs_n_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      wr_req_q <= wr_req_d;
      rd_dv_q  <= rd_capture;
      if (rd_capture) rdata_q <= shift_rx_byte;
    end
  end

  assign o_fram_wr_req = wr_req_q;
  assign o_fram_rd_dv  = rd_dv_q;
  assign om_fram_rdata = rdata_q;
  assign o_fram_rdy    = rdy_q;
  assign o_fram_err    = err_q;
  assign o_spi_cs_n    = cs_n_q;

endmodule
